// File: rtl/pio_debounce_irq.sv
// Multi-channel input PIO: two-flop synchroniser, per-channel debounce, selectable
// edge capture with write-1-to-clear, and a masked level interrupt on an Avalon-MM slave.
module pio_debounce_irq #(
    parameter int          WIDTH    = 4,
    parameter int          DB_WIDTH = 16,
    parameter int unsigned DB_RESET = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq,
    output logic [31:0]       readdata
);

    localparam logic [2:0] ADDR_DATA  = 3'd0;
    localparam logic [2:0] ADDR_RAW   = 3'd1;
    localparam logic [2:0] ADDR_MASK  = 3'd2;
    localparam logic [2:0] ADDR_EDGE  = 3'd3;
    localparam logic [2:0] ADDR_RISE  = 3'd4;
    localparam logic [2:0] ADDR_FALL  = 3'd5;
    localparam logic [2:0] ADDR_LIMIT = 3'd6;

    logic [WIDTH-1:0]    r_s1;
    logic [WIDTH-1:0]    r_s2;
    logic [WIDTH-1:0]    r_data;
    logic [WIDTH-1:0]    r_prev;
    logic [DB_WIDTH-1:0] r_cnt [WIDTH];
    logic [DB_WIDTH-1:0] r_db_limit;
    logic [WIDTH-1:0]    r_irq_mask;
    logic [WIDTH-1:0]    r_edge_capture;
    logic [WIDTH-1:0]    r_rise_en;
    logic [WIDTH-1:0]    r_fall_en;
    logic [31:0]         r_readdata;

    logic                w_wr;
    logic [DB_WIDTH-1:0] w_lim_m1;
    logic [WIDTH-1:0]    w_ev;
    logic [WIDTH-1:0]    w_clr;
    logic [31:0]         w_rd_mux;
    logic                w_unused_wdata;

    assign w_wr = chipselect & ~write_n;

    // A zero limit behaves like one so a mismatch is still accepted after one cycle.
    assign w_lim_m1 = (r_db_limit == '0) ? '0 : r_db_limit - DB_WIDTH'(1);

    assign w_ev  = (r_data & ~r_prev & r_rise_en) | (~r_data & r_prev & r_fall_en);
    assign w_clr = (w_wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_data <= '0;
            r_prev <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1   <= in_port;
            r_s2   <= r_s1;
            r_prev <= r_data;
            // >= rather than == so that lowering the limit mid-count never stalls a channel.
            for (int i = 0; i < WIDTH; i++) begin
                if (r_s2[i] == r_data[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] >= w_lim_m1) begin
                    r_data[i] <= r_s2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + DB_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_mask     <= '0;
            r_edge_capture <= '0;
            r_rise_en      <= '0;
            r_fall_en      <= '0;
            r_db_limit     <= DB_WIDTH'(DB_RESET);
        end else begin
            // A new event on a bit being cleared in the same cycle keeps that bit set.
            r_edge_capture <= (r_edge_capture & ~w_clr) | w_ev;
            if (w_wr) begin
                case (address)
                    ADDR_MASK:  r_irq_mask <= writedata[WIDTH-1:0];
                    ADDR_RISE:  r_rise_en  <= writedata[WIDTH-1:0];
                    ADDR_FALL:  r_fall_en  <= writedata[WIDTH-1:0];
                    ADDR_LIMIT: r_db_limit <= writedata[DB_WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:  w_rd_mux[WIDTH-1:0]    = r_data;
            ADDR_RAW:   w_rd_mux[WIDTH-1:0]    = r_s2;
            ADDR_MASK:  w_rd_mux[WIDTH-1:0]    = r_irq_mask;
            ADDR_EDGE:  w_rd_mux[WIDTH-1:0]    = r_edge_capture;
            ADDR_RISE:  w_rd_mux[WIDTH-1:0]    = r_rise_en;
            ADDR_FALL:  w_rd_mux[WIDTH-1:0]    = r_fall_en;
            ADDR_LIMIT: w_rd_mux[DB_WIDTH-1:0] = r_db_limit;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge_capture & r_irq_mask);

    // Upper write-data bits beyond the register widths are intentionally ignored.
    assign w_unused_wdata = ^writedata;

endmodule

// File: tb/tb_pio_debounce_irq.sv
// Bench for pio_debounce_irq: a cycle model built from the register-level rules is
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_pio_debounce_irq;

    localparam int          WIDTH    = 4;
    localparam int          DB_WIDTH = 16;
    localparam int unsigned DB_RESET = 50000;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic        irq;
    logic [31:0] readdata;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pio_debounce_irq #(.WIDTH(WIDTH), .DB_WIDTH(DB_WIDTH), .DB_RESET(DB_RESET)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .irq        (irq),
        .readdata   (readdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the raw input reaches the debouncer two cycles late; a channel adopts the
    // synchronised value once it has disagreed for max(limit,1) consecutive cycles.
    bit          m_valid = 1'b0;
    logic [3:0]  m_s1, m_s2, m_data, m_prev, m_mask, m_ec, m_re, m_fe;
    logic [15:0] m_lim;
    logic [31:0] m_rd;
    int          m_run [4];

    function automatic logic [31:0] mread(input logic [2:0] a);
        case (a)
            3'd0:    return {28'b0, m_data};
            3'd1:    return {28'b0, m_s2};
            3'd2:    return {28'b0, m_mask};
            3'd3:    return {28'b0, m_ec};
            3'd4:    return {28'b0, m_re};
            3'd5:    return {28'b0, m_fe};
            3'd6:    return {16'b0, m_lim};
            default: return 32'b0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [3:0] nd;
        logic [3:0] ev;
        logic [3:0] clr;
        int         nrun [4];
        int         lim;
        if (reset) begin
            m_valid <= 1'b1;
            m_s1 <= 0; m_s2 <= 0; m_data <= 0; m_prev <= 0;
            m_mask <= 0; m_ec <= 0; m_re <= 0; m_fe <= 0;
            m_lim <= 16'(DB_RESET);
            m_rd <= 0;
            for (int i = 0; i < 4; i++) m_run[i] <= 0;
        end else if (m_valid) begin
            lim = (m_lim == 16'd0) ? 1 : int'(m_lim);
            nd  = m_data;
            for (int i = 0; i < 4; i++) begin
                nrun[i] = (m_s2[i] != m_data[i]) ? m_run[i] + 1 : 0;
                if (nrun[i] >= lim) begin
                    nd[i]   = m_s2[i];
                    nrun[i] = 0;
                end
            end
            ev  = 4'b0;
            for (int i = 0; i < 4; i++) begin
                if (m_data[i] && !m_prev[i] && m_re[i]) ev[i] = 1'b1;
                if (!m_data[i] && m_prev[i] && m_fe[i]) ev[i] = 1'b1;
            end
            clr = (chipselect && !write_n && address == 3'd3) ? writedata[3:0] : 4'b0;
            m_rd   <= mread(address);
            m_ec   <= (m_ec & ~clr) | ev;
            m_s1   <= in_port;
            m_s2   <= m_s1;
            m_prev <= m_data;
            m_data <= nd;
            for (int i = 0; i < 4; i++) m_run[i] <= nrun[i];
            if (chipselect && !write_n) begin
                case (address)
                    3'd2: m_mask <= writedata[3:0];
                    3'd4: m_re   <= writedata[3:0];
                    3'd5: m_fe   <= writedata[3:0];
                    3'd6: m_lim  <= writedata[15:0];
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_readdata", readdata, m_rd);
            chk("model_irq", {31'b0, irq}, {31'b0, |(m_ec & m_mask)});
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        address = a;
        @(negedge clk);
        v = readdata;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int          n;
        bit          seen;

        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        address = 3'd0; writedata = 32'd0; in_port = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int a = 0; a < 8; a++) begin
            rd(3'(a), v);
            chk($sformatf("reset_reg%0d", a), v, (a == 6) ? 32'(DB_RESET) : 32'd0);
        end
        chk("reset_irq", {31'b0, irq}, 32'd0);

        // Held rising input: data visible 6 cycles after the change, +1 for read latency.
        wr(3'd6, 32'd4); wr(3'd4, 32'hF); wr(3'd2, 32'h1);
        address = 3'd0;
        in_port[0] = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk); n++;
            if (readdata[0]) seen = 1'b1;
        end
        chk("rise_latency", 32'(n), 32'd7);
        chk("rise_irq", {31'b0, irq}, 32'd1);
        rd(3'd3, v); chk("rise_capture", v, 32'h1);

        // Three-cycle glitch is rejected with limit 4.
        wr(3'd3, 32'h1);
        chk("clr0_irq", {31'b0, irq}, 32'd0);
        in_port[1] = 1'b1;
        repeat (3) @(negedge clk);
        in_port[1] = 1'b0;
        repeat (10) @(negedge clk);
        rd(3'd0, v); chk("glitch_data", v, 32'h1);
        rd(3'd3, v); chk("glitch_capture", v, 32'h0);
        chk("glitch_irq", {31'b0, irq}, 32'd0);

        // Falling-edge capture and write-1-to-clear.
        wr(3'd4, 32'h0);
        in_port[2] = 1'b1;
        repeat (10) @(negedge clk);
        wr(3'd5, 32'h4);
        in_port[2] = 1'b0;
        repeat (10) @(negedge clk);
        rd(3'd3, v); chk("fall_capture", v, 32'h4);
        wr(3'd2, 32'h4);
        chk("fall_irq", {31'b0, irq}, 32'd1);
        wr(3'd3, 32'h4);
        chk("clr2_irq", {31'b0, irq}, 32'd0);
        rd(3'd3, v); chk("clr2_capture", v, 32'h0);

        // Clear collides with a fresh event on the same bit: the event wins.
        wr(3'd4, 32'h3); wr(3'd5, 32'h3);
        in_port[1] = 1'b1;
        repeat (10) @(negedge clk);
        in_port[0] = 1'b0;
        repeat (10) @(negedge clk);
        rd(3'd3, v); chk("both_capture", v, 32'h3);
        in_port[0] = 1'b1;
        repeat (6) @(negedge clk);
        wr(3'd3, 32'h1);
        rd(3'd3, v); chk("collide_capture", v, 32'h3);
        wr(3'd3, 32'h2);
        rd(3'd3, v); chk("clr1_capture", v, 32'h1);

        // Zero limit: data follows the synchronised input one cycle later.
        wr(3'd6, 32'd0);
        address = 3'd0;
        in_port[3] = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk); n++;
            if (readdata[3]) seen = 1'b1;
        end
        chk("zero_limit_latency", 32'(n), 32'd4);

        // Lower the limit from 1000 to 2 once the counter has reached 500.
        wr(3'd6, 32'd1000);
        in_port[3] = 1'b0;
        repeat (502) @(negedge clk);
        wr(3'd6, 32'd2);
        address = 3'd0;
        n = 503; seen = 1'b0;
        while (!seen && n < 1600) begin
            @(negedge clk); n++;
            if (!readdata[3]) seen = 1'b1;
        end
        chk("lower_limit_latency", 32'(n), 32'd505);
        rd(3'd6, v); chk("limit_readback", v, 32'd2);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
